// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multi-port register file.
// Optional feature macro used by the register file: REGFILE_ZERO_REG_EN.
package regfile_pkg;

  localparam int DEFAULT_DATA_W   = 16;
  localparam int DEFAULT_NUM_REGS = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback-side bus of the register file: write, two reads, issue and clear.
// The issuing stage drives the master modport; the register file uses the slave modport.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_REGS = DEFAULT_NUM_REGS
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en1;
  logic [ADDR_W-1:0] rd_addr1;
  logic [DATA_W-1:0] rd_data1;
  logic              rd_busy1;
  logic              rd_en2;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data2;
  logic              rd_busy2;
  logic              issue_en;
  logic [ADDR_W-1:0] issue_addr;
  logic              clr_start;
  logic              clr_busy;

  modport master (
    output wr_en, wr_addr, wr_data,
    output rd_en1, rd_addr1, rd_en2, rd_addr2,
    output issue_en, issue_addr, clr_start,
    input  rd_data1, rd_busy1, rd_data2, rd_busy2, clr_busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  rd_en1, rd_addr1, rd_en2, rd_addr2,
    input  issue_en, issue_addr, clr_start,
    output rd_data1, rd_busy1, rd_data2, rd_busy2, clr_busy
  );

endinterface

// File: rtl/regfile_clear_fsm.sv
// Sequential clear engine: walks clr_idx over every register, one per cycle.
// While active it owns the write path, so normal writes, issues and restarts are dropped.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_idx
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  clr_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] idx_reg, idx_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    clr_busy   = 1'b0;
    clr_we     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (clr_start) begin
          state_next = CLEAR;
          idx_next   = '0;
        end
      end
      CLEAR: begin
        clr_busy = 1'b1;
        clr_we   = 1'b1;
        // Natural wrap of the index leaves it at 0 for the next clear.
        idx_next = idx_reg + 1'b1;
        if (idx_reg == LAST_IDX) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  assign clr_idx = idx_reg;

endmodule

// File: rtl/regfile_mp.sv
// Two-read / one-write register file with write bypass, pending-write scoreboard and clear engine.
// Define REGFILE_ZERO_REG_EN to hardwire register 0 to zero.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_REGS = DEFAULT_NUM_REGS
) (
  input logic        clk,
  input logic        reset,
  regfile_mp_if.slave bus
);

  localparam int ADDR_W = $clog2(NUM_REGS);

  logic              clr_busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_idx;

  regfile_clear_fsm #(
    .NUM_REGS (NUM_REGS)
  ) u_clear_fsm (
    .clk       (clk),
    .reset     (reset),
    .clr_start (bus.clr_start),
    .clr_busy  (clr_busy),
    .clr_we    (clr_we),
    .clr_idx   (clr_idx)
  );

  assign bus.clr_busy = clr_busy;

  logic wr_ok;
  logic issue_ok;

`ifdef REGFILE_ZERO_REG_EN
  assign wr_ok    = bus.wr_en    & ~clr_we & (bus.wr_addr    != '0);
  assign issue_ok = bus.issue_en & ~clr_we & (bus.issue_addr != '0);
`else
  assign wr_ok    = bus.wr_en    & ~clr_we;
  assign issue_ok = bus.issue_en & ~clr_we;
`endif

  // Post-edge view of every register; reads sample this so bypass falls out for free.
  logic [DATA_W-1:0]   mem_view [NUM_REGS];
  logic [NUM_REGS-1:0] busy_view;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [DATA_W-1:0] mem_reg, mem_next;
      logic              busy_reg, busy_next;

      always_comb begin
        mem_next  = mem_reg;
        busy_next = busy_reg;
        if (clr_we && (clr_idx == ADDR_W'(gi))) begin
          mem_next  = '0;
          busy_next = 1'b0;
        end else begin
          if (wr_ok && (bus.wr_addr == ADDR_W'(gi))) begin
            mem_next  = bus.wr_data;
            busy_next = 1'b0;
          end
          // A same-cycle issue is a newer producer than the write, so it wins.
          if (issue_ok && (bus.issue_addr == ADDR_W'(gi))) begin
            busy_next = 1'b1;
          end
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          mem_reg  <= '0;
          busy_reg <= 1'b0;
        end else begin
          mem_reg  <= mem_next;
          busy_reg <= busy_next;
        end
      end

      assign mem_view[gi]  = mem_next;
      assign busy_view[gi] = busy_next;
    end
  endgenerate

  logic [DATA_W-1:0] rd_data1_reg, rd_data2_reg;
  logic              rd_busy1_reg, rd_busy2_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data1_reg <= '0;
      rd_busy1_reg <= 1'b0;
      rd_data2_reg <= '0;
      rd_busy2_reg <= 1'b0;
    end else begin
      if (bus.rd_en1) begin
        rd_data1_reg <= mem_view[bus.rd_addr1];
        rd_busy1_reg <= busy_view[bus.rd_addr1];
      end
      if (bus.rd_en2) begin
        rd_data2_reg <= mem_view[bus.rd_addr2];
        rd_busy2_reg <= busy_view[bus.rd_addr2];
      end
    end
  end

  assign bus.rd_data1 = rd_data1_reg;
  assign bus.rd_busy1 = rd_busy1_reg;
  assign bus.rd_data2 = rd_data2_reg;
  assign bus.rd_busy2 = rd_busy2_reg;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed test-plan steps followed by random traffic
// compared against an array/counter reference model of the register file behaviour.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int DW = 16;
  localparam int NR = 16;
  localparam int AW = 4;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(DW), .NUM_REGS(NR)) bus ();

  regfile_mp #(.DATA_W(DW), .NUM_REGS(NR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: register contents, pending bits, clear progress, last read results.
  logic [DW-1:0] m_mem  [NR];
  bit            m_busy [NR];
  int            m_clr_left;
  int            m_clr_ptr;
  logic [DW-1:0] e_rd1, e_rd2;
  bit            e_b1, e_b2;
  int            cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_clr_left = 0;
    m_clr_ptr  = 0;
    e_rd1 = '0; e_rd2 = '0; e_b1 = 1'b0; e_b2 = 1'b0;
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, "_rd_data1"}, 32'(bus.rd_data1), 32'(e_rd1));
    check({pfx, "_rd_busy1"}, 32'(bus.rd_busy1), 32'(e_b1));
    check({pfx, "_rd_data2"}, 32'(bus.rd_data2), 32'(e_rd2));
    check({pfx, "_rd_busy2"}, 32'(bus.rd_busy2), 32'(e_b2));
    check({pfx, "_clr_busy"}, 32'(bus.clr_busy), 32'(m_clr_left > 0));
  endtask

  // One clock cycle: drive inputs, advance the model by the spec rules, compare after the edge.
  task automatic step(input bit we, input int wa, input int wd,
                      input bit r1, input int a1, input bit r2, input int a2,
                      input bit ie, input int ia, input bit cs);
    bus.wr_en      = we;
    bus.wr_addr    = AW'(wa);
    bus.wr_data    = DW'(wd);
    bus.rd_en1     = r1;
    bus.rd_addr1   = AW'(a1);
    bus.rd_en2     = r2;
    bus.rd_addr2   = AW'(a2);
    bus.issue_en   = ie;
    bus.issue_addr = AW'(ia);
    bus.clr_start  = cs;
    @(posedge clk);
    if (m_clr_left > 0) begin
      m_mem[m_clr_ptr]  = '0;
      m_busy[m_clr_ptr] = 1'b0;
      m_clr_ptr  = (m_clr_ptr + 1) % NR;
      m_clr_left = m_clr_left - 1;
    end else begin
      if (we && !(ZERO_REG && wa == 0)) begin
        m_mem[wa]  = DW'(wd);
        m_busy[wa] = 1'b0;
      end
      if (ie && !(ZERO_REG && ia == 0)) m_busy[ia] = 1'b1;
      if (cs) begin
        m_clr_left = NR;
        m_clr_ptr  = 0;
      end
    end
    if (r1) begin e_rd1 = m_mem[a1]; e_b1 = m_busy[a1]; end
    if (r2) begin e_rd2 = m_mem[a2]; e_b2 = m_busy[a2]; end
    #1;
    cyc++;
    $display("cyc %0d: we=%0d wa=%0d wd=%h r1=%0d a1=%0d r2=%0d a2=%0d ie=%0d ia=%0d cs=%0d -> d1=%h b1=%0d d2=%h b2=%0d cb=%0d",
             cyc, we, wa, DW'(wd), r1, a1, r2, a2, ie, ia, cs,
             bus.rd_data1, bus.rd_busy1, bus.rd_data2, bus.rd_busy2, bus.clr_busy);
    check_outputs("step");
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset pulse between edges; outputs must drop before any clock edge.
  task automatic do_reset();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    $display("reset asserted at %0t", $time);
    check_outputs("reset");
    #2;
    reset = 1'b1;
  endtask

  int busy_cnt;

  initial begin
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_en1 = 0; bus.rd_addr1 = '0; bus.rd_en2 = 0; bus.rd_addr2 = '0;
    bus.issue_en = 0; bus.issue_addr = '0; bus.clr_start = 0;
    model_reset();
    #12;
    check_outputs("por");
    reset = 1'b1;

    // Reset values mid-traffic
    step(1, 5, 16'hA5A5, 1, 5, 1, 5, 1, 6, 0);
    step(1, 6, 16'h5A5A, 1, 6, 0, 0, 0, 0, 0);
    do_reset();
    step(0, 0, 0, 1, 5, 0, 0, 0, 0, 0);
    check("reset_r5_zero", 32'(bus.rd_data1), 32'h0);

    // Write then read
    step(1, 3, 16'hBEEF, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 3, 0, 0, 0, 0, 0);
    check("wr_rd_r3", 32'(bus.rd_data1), 32'hBEEF);

    // Bypass on both ports
    step(1, 7, 16'h1234, 1, 7, 1, 7, 0, 0, 0);
    check("bypass_d1", 32'(bus.rd_data1), 32'h1234);
    check("bypass_d2", 32'(bus.rd_data2), 32'h1234);
    check("bypass_b1", 32'(bus.rd_busy1), 32'h0);

    // Scoreboard
    step(0, 0, 0, 0, 0, 0, 0, 1, 4, 0);
    step(0, 0, 0, 1, 4, 0, 0, 0, 0, 0);
    check("sb_issue", 32'(bus.rd_busy1), 32'h1);
    step(1, 4, 16'h0055, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 4, 0, 0, 0, 0, 0);
    check("sb_write_busy", 32'(bus.rd_busy1), 32'h0);
    check("sb_write_data", 32'(bus.rd_data1), 32'h0055);
    step(1, 4, 16'h0066, 0, 0, 1, 4, 1, 4, 0);
    check("sb_same_cycle_bypass", 32'(bus.rd_busy2), 32'h1);
    step(0, 0, 0, 1, 4, 0, 0, 0, 0, 0);
    check("sb_same_cycle", 32'(bus.rd_busy1), 32'h1);

    // Register 0 behaviour
    step(1, 0, 16'hFFFF, 0, 0, 1, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    check("r0_data", 32'(bus.rd_data1), ZERO_REG ? 32'h0 : 32'hFFFF);
    check("r0_busy", 32'(bus.rd_busy1), ZERO_REG ? 32'h0 : 32'h1);

    // Clear: fill, start, drop a write to r2, count busy cycles
    for (int i = 0; i < NR; i++) step(1, i, 16'h1000 + i, 0, 0, 0, 0, 1, (i + 1) % NR, 0);
    busy_cnt = 0;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    if (bus.clr_busy) busy_cnt++;
    for (int i = 0; i < 20; i++) begin
      step(i == 3, 2, 16'hDEAD, 1, i % NR, 1, (i + 1) % NR, i == 4, 9, i == 6);
      if (bus.clr_busy) busy_cnt++;
    end
    check("clr_busy_cycles", 32'(busy_cnt), 32'(NR));
    for (int i = 0; i < NR; i += 2) begin
      step(0, 0, 0, 1, i, 1, i + 1, 0, 0, 0);
      check("clr_zero_p1", 32'(bus.rd_data1), 32'h0);
      check("clr_zero_p2", 32'(bus.rd_data2), 32'h0);
    end

    // Reset at clear cycle 5
    for (int i = 0; i < NR; i++) step(1, i, 16'h2000 + i, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, i, 0, 0, 0, 0, 0);
    do_reset();
    check("clr_abort", 32'(bus.clr_busy), 32'h0);
    step(0, 0, 0, 1, 12, 1, 13, 0, 0, 0);

    // Random traffic with address collisions favoured
    for (int n = 0; n < 300; n++) begin
      int narrow;
      narrow = ($urandom_range(0, 1) == 1) ? 3 : NR - 1;
      step($urandom_range(0, 1), $urandom_range(0, narrow), $urandom,
           $urandom_range(0, 1), $urandom_range(0, narrow),
           $urandom_range(0, 1), $urandom_range(0, narrow),
           $urandom_range(0, 2) == 0, $urandom_range(0, narrow),
           $urandom_range(0, 39) == 0);
      if ($urandom_range(0, 99) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the 16-bit RISC datapath. It has two synchronous read ports, one write port with write-to-read bypass, a per-register pending-write scoreboard for hazard detection, and a sequential clear engine. It sits between decode (reads and issue) and writeback (writes), and it replaces the fixed 16x16 single-cycle register file.

## Interface
- `DATA_W`, 16: register width in bits
- `NUM_REGS`, 16: number of registers; must be a power of two, at least 2
- `ADDR_W`, $clog2(NUM_REGS): address width (derived)
- `clk`  in  1  clock; all state changes on the rising edge
- `reset`  in  1  reset, asynchronous, active-low
- `wr_en`  in  1  write strobe
- `wr_addr`  in  ADDR_W  write address
- `wr_data`  in  DATA_W  write data
- `rd_en1` / `rd_en2`  in  1  read strobe, per port
- `rd_addr1` / `rd_addr2`  in  ADDR_W  read address, per port
- `rd_data1` / `rd_data2`  out  DATA_W  registered read data
- `rd_busy1` / `rd_busy2`  out  1  registered scoreboard bit of the register read
- `issue_en`  in  1  marks `issue_addr` as having a pending write
- `issue_addr`  in  ADDR_W  destination of the issued instruction
- `clr_start`  in  1  starts a sequential clear of all registers
- `clr_busy`  out  1  clear engine is active

## Operation
- **Reset state.** Asserting `reset` (low) immediately forces:
  - all registers and all busy bits to 0
  - `rd_data*` and `rd_busy*` to 0
  - `clr_busy` to 0, and the FSM to IDLE
- **Write.** When `wr_en=1` at an edge, `wr_addr` is updated and its busy bit is cleared.
- **Issue.** When `issue_en=1` at an edge, the busy bit of `issue_addr` is set.
  - Issue and write to the same address in the same cycle: data is written and the busy bit ends set, because the newer producer wins.
- **Read.** When `rd_enN=1` at an edge:
  - `rd_dataN` and `rd_busyN` take the post-edge view of `rd_addrN`.
  - A write to the same address in the same cycle is bypassed: `rd_dataN=wr_data`, `rd_busyN=0`, unless the same address is also issued that cycle, in which case `rd_busyN=1`.
  - When `rd_enN=0`, the outputs hold their value.
- **Both ports.** The two read ports are independent; both may read the same address.
- **Clear FSM.** States are IDLE and CLEAR, with index `clr_idx` (ADDR_W bits).
  - IDLE to CLEAR on `clr_start`, with `clr_idx=0`.
  - In CLEAR, each cycle zeroes `mem[clr_idx]` and `busy[clr_idx]`, then increments `clr_idx`.
  - CLEAR to IDLE after `clr_idx=NUM_REGS-1` is processed; the index wraps to 0.
  - In CLEAR, `wr_en`, `issue_en` and `clr_start` are ignored (dropped, not queued).
  - Reads remain legal. The clear write is bypassed like a normal write: reading `clr_idx` in that cycle returns 0 with busy 0.
  - `clr_start` in CLEAR has no effect.
- **Reset during CLEAR** aborts the clear and gives the reset state above.

## Timing
- Read latency is 1 cycle: address at edge N, data valid after edge N.
- Write-to-read latency is 0 extra cycles, via the bypass.
- The scoreboard updates at the same edge as the issue or write.
- `clr_busy` rises at the edge that samples `clr_start` and stays high exactly `NUM_REGS` cycles.
- A full clear costs `NUM_REGS` cycles. The first accepted write is at the edge where `clr_busy` is sampled 0.

## Configuration
- Macro: `REGFILE_ZERO_REG_EN`.
- **Defined:** register 0 is hardwired to zero.
  - Writes to address 0 are dropped.
  - Issue to address 0 never sets busy.
  - Reads of address 0 always give `rd_data=0` and `rd_busy=0`, including when bypassing.
- **Undefined:** register 0 is an ordinary register.

## Structure
- Package `regfile_pkg` holds:
  - the clear FSM state enum `clr_state_t` (IDLE, CLEAR)
  - the default `DATA_W` and `NUM_REGS` constants
- Sub-module `regfile_clear_fsm` holds the FSM and `clr_idx`. Its outputs are `clr_busy`, `clr_we` and `clr_idx`.
- The top level holds the storage array, the busy vector, the bypass muxes and the read registers.

## Test plan
- **Reset values.** Reset low mid-traffic, then release: all `rd_data*`, `rd_busy*` and `clr_busy` read 0; reading r5 returns 0x0000.
- **Write then read.** Write r3=0xBEEF, then `rd_en1` r3 on the next cycle: `rd_data1=0xBEEF` one cycle later.
- **Bypass.** In one cycle write r7=0x1234 and read r7 on both ports: both `rd_data` are 0x1234 and `rd_busy` is 0 after the edge.
- **Scoreboard.**
  - Issue r4, then read r4: `rd_busy1=1`.
  - Write r4=0x0055, then read r4: `rd_busy1=0`, data 0x0055.
  - Issue and write r4 in the same cycle: `rd_busy=1` afterwards.
- **Clear.** Fill all registers, pulse `clr_start`:
  - `clr_busy` is high for 16 cycles.
  - A write to r2 during the clear is dropped.
  - All reads return 0 afterwards.
  - Reset at clear cycle 5 gives `clr_busy=0` immediately.
- **`REGFILE_ZERO_REG_EN` defined.** Write r0=0xFFFF and issue r0: reading r0 gives data 0 and busy 0. Without the macro the read gives 0xFFFF.
